// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R/I-ALU, beq, jal).
// Moore outputs except the mem_ready/zero qualified enables; all outputs held low in reset.
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       retire,
    output logic       halted
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StHalt     = 4'd11
    } state_e;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpRAlu = 7'b0110011;
    localparam logic [6:0] OpIAlu = 7'b0010011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpBeq  = 7'b1100011;

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRAlu:     state_d = StExecR;
                    OpIAlu:     state_d = StExecI;
                    OpJal:      state_d = StJal;
                    OpBeq:      state_d = StBeq;
                    default:    state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
                endcase
            end
            StMemAdr: begin
                if (op == OpLw) begin
                    state_d = StMemRead;
                end else if (op == OpSw) begin
                    state_d = StMemWrite;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StJal:      state_d = StAluWb;
            StBeq:      state_d = StFetch;
            StHalt:     state_d = StHalt;
            default:    state_d = StFetch;
        endcase
    end

    // Outputs are gated by rst_n so a mid-instruction reset drops every enable at once.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_src    = 2'b00;
        retire     = 1'b0;
        halted     = 1'b0;
        if (rst_n) begin
            case (op)
                OpSw:    imm_src = 2'b01;
                OpBeq:   imm_src = 2'b10;
                OpJal:   imm_src = 2'b11;
                default: imm_src = 2'b00;
            endcase
            unique case (state_q)
                StFetch: begin
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                StDecode: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                StMemAdr: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                StMemRead: begin
                    adr_src = 1'b1;
                end
                StMemWb: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                StMemWrite: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    retire    = mem_ready;
                end
                StExecR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                StExecI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
                StAluWb: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                StJal: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                StBeq: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_write  = zero;
                    retire    = 1'b1;
                end
                StHalt: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors for each instruction class.
// A second instance with HALT_ON_ILLEGAL=0 shares all inputs to cover the skip behaviour.
module tb_multicycle_controller;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpRAlu = 7'b0110011;
    localparam logic [6:0] OpIAlu = 7'b0010011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpIll  = 7'b1110011;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, halted;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s, retire_s, halted_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s, imm_src_s;

    int n_checks;
    int n_fail;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src), .retire(retire),
        .halted(halted)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut_skip (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write_s), .adr_src(adr_src_s), .mem_write(mem_write_s),
        .ir_write(ir_write_s), .reg_write(reg_write_s), .result_src(result_src_s),
        .alu_src_a(alu_src_a_s), .alu_src_b(alu_src_b_s), .alu_op(alu_op_s),
        .imm_src(imm_src_s), .retire(retire_s), .halted(halted_s)
    );

    wire [16:0] outs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                        alu_src_a, alu_src_b, alu_op, imm_src, retire, halted};
    wire [16:0] outs_s = {pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s,
                          result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s, imm_src_s,
                          retire_s, halted_s};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs expected fields in the same order as outs.
    function automatic logic [16:0] e(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] aop, input logic [1:0] imm,
                                      input logic ret, input logic hlt);
        return {pcw, adr, mw, irw, rw, rs, a, b, aop, imm, ret, hlt};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; op = OpSw; mem_ready = 1'b1; zero = 1'b1;
        #2;
        n_checks++;
        if (outs !== 17'd0) begin
            n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, 17'd0);
        end
        n_checks++;
        if (outs_s !== 17'd0) begin
            n_fail++; $display("FAIL reset_outs_skip: got %b expected %b", outs_s, 17'd0);
        end
        @(posedge clk); #1;
        n_checks++;
        if (outs !== 17'd0) begin
            n_fail++; $display("FAIL reset_held: got %b expected %b", outs, 17'd0);
        end
        rst_n = 1'b1;
        zero = 1'b0;
    endtask

    task automatic test_add;
        logic [16:0] exp [4];
        logic        mr [4];
        op = OpRAlu;
        exp[0] = e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        exp[1] = e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
        exp[2] = e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
        exp[3] = e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        mr = '{1, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            #2;
            n_checks++;
            if (outs !== exp[i]) begin
                n_fail++; $display("FAIL add_c%0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dut.state_q !== 4'd0) begin
            n_fail++; $display("FAIL add_end_state: got %0d expected 0", dut.state_q);
        end
    endtask

    task automatic test_lw;
        logic [16:0] exp [7];
        logic        mr [7];
        op = OpLw;
        exp[0] = e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        exp[1] = e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
        exp[2] = e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
        exp[3] = e(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        exp[4] = exp[3];
        exp[5] = exp[3];
        exp[6] = e(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        mr = '{1, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            #2;
            n_checks++;
            if (outs !== exp[i]) begin
                n_fail++; $display("FAIL lw_c%0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dut.state_q !== 4'd0) begin
            n_fail++; $display("FAIL lw_end_state: got %0d expected 0", dut.state_q);
        end
    endtask

    task automatic test_sw;
        logic [16:0] exp [5];
        logic        mr [5];
        op = OpSw;
        exp[0] = e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
        exp[1] = e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0);
        exp[2] = e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0);
        exp[3] = e(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
        exp[4] = e(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0);
        mr = '{1, 1, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #2;
            n_checks++;
            if (outs !== exp[i]) begin
                n_fail++; $display("FAIL sw_c%0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dut.state_q !== 4'd0) begin
            n_fail++; $display("FAIL sw_end_state: got %0d expected 0", dut.state_q);
        end
    endtask

    task automatic test_ialu_fetch_wait;
        logic [16:0] exp [5];
        logic        mr [5];
        op = OpIAlu;
        exp[0] = e(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        exp[1] = e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        exp[2] = e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
        exp[3] = e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0);
        exp[4] = e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        mr = '{0, 1, 1, 1, 1};
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #2;
            n_checks++;
            if (outs !== exp[i]) begin
                n_fail++; $display("FAIL ialu_c%0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal;
        logic [16:0] exp [4];
        op = OpJal;
        mem_ready = 1'b1;
        exp[0] = e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 0, 0);
        exp[1] = e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 0, 0);
        exp[2] = e(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0, 0);
        exp[3] = e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            n_checks++;
            if (outs !== exp[i]) begin
                n_fail++; $display("FAIL jal_c%0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq;
        logic [16:0] exp [3];
        op = OpBeq;
        mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            exp[0] = e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
            exp[1] = e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0);
            exp[2] = e(z[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 1, 0);
            for (int i = 0; i < 3; i++) begin
                #2;
                n_checks++;
                if (outs !== exp[i]) begin
                    n_fail++;
                    $display("FAIL beq_z%0d_c%0d: got %b expected %b", z, i + 1, outs, exp[i]);
                end
                @(posedge clk); #1;
            end
            n_checks++;
            if (dut.state_q !== 4'd0) begin
                n_fail++; $display("FAIL beq_z%0d_end_state: got %0d expected 0", z, dut.state_q);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal;
        logic [16:0] fetch_v, decode_v, halt_v;
        op = OpIll;
        mem_ready = 1'b1;
        fetch_v  = e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        decode_v = e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
        halt_v   = e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
        #2;
        n_checks++;
        if (outs !== fetch_v || outs_s !== fetch_v) begin
            n_fail++; $display("FAIL ill_fetch: got %b/%b expected %b", outs, outs_s, fetch_v);
        end
        @(posedge clk); #3;
        n_checks++;
        if (outs !== decode_v || outs_s !== decode_v) begin
            n_fail++; $display("FAIL ill_decode: got %b/%b expected %b", outs, outs_s, decode_v);
        end
        @(posedge clk); #3;
        n_checks++;
        if (outs_s !== fetch_v) begin
            n_fail++; $display("FAIL ill_skip_to_fetch: got %b expected %b", outs_s, fetch_v);
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (outs !== halt_v || retire_s !== 1'b0) begin
                n_fail++;
                $display("FAIL ill_halt_c%0d: got %b retire_skip %b expected %b retire_skip 0",
                         i + 1, outs, retire_s, halt_v);
            end
            @(posedge clk); #3;
        end
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (outs !== 17'd0) begin
            n_fail++; $display("FAIL rst_from_halt: got %b expected %b", outs, 17'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        op = OpSw;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #2;
        n_checks++;
        if (mem_write !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre_write: got %b expected 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || outs !== 17'd0) begin
            n_fail++; $display("FAIL rst_mid_drop: got %b expected %b", outs, 17'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (outs !== e(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0)) begin
            n_fail++; $display("FAIL rst_mid_fetch_wait: got %b expected ir_write=0 fetch", outs);
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (outs !== e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0)) begin
            n_fail++; $display("FAIL rst_mid_fetch_ready: got %b expected ir_write=1 fetch", outs);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dut.state_q !== 4'd1) begin
            n_fail++; $display("FAIL rst_mid_decode: got %0d expected 1", dut.state_q);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_ialu_fetch_wait();
        test_jal();
        test_beq();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
